// File: rtl/wb_initiator_if.sv
// wb_initiator_if: Wishbone initiator bus bundle.
// Ports: wbm_cyc_o/wbm_stb_o/wbm_we_o/wbm_adr_o/wbm_dat_o/wbm_sel_o driven by the initiator,
//        wbm_dat_i/wbm_ack_i driven by the responder.
interface wb_initiator_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone burst initiator turning one command into 1..16 single beats.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset;
//        cmd_* command request (valid/ready, we, adr, dat, sel, len = beats-1);
//        rsp_* one-cycle response per beat (dat, err = timeout, last);
//        wbm   Wishbone master bus bundle.
module wb_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic [3:0]  cmd_len,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last,
    wb_initiator_if.master wbm
);
    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  beats_q, beats_d;
    logic [7:0]  wait_q, wait_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_last_q, rsp_last_d;

    // beats_q holds the number of beats still to run after the current one.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        beats_d     = beats_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = 32'd0;
        rsp_err_d   = 1'b0;
        rsp_last_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = STROBE;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    beats_d = cmd_len;
                    wait_d  = 8'd0;
                end
            end
            STROBE: begin
                if (wbm.wbm_ack_i) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? 32'd0 : wbm.wbm_dat_i;
                    if (beats_q == 4'd0) begin
                        rsp_last_d = 1'b1;
                        cyc_d      = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        beats_d = beats_q - 4'd1;
                        adr_d   = adr_q + 32'd4;
                        state_d = GAP;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            GAP: begin
                stb_d   = 1'b1;
                wait_d  = 8'd0;
                state_d = STROBE;
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'd0;
            beats_q     <= 4'd0;
            wait_q      <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            beats_q     <= beats_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_dat       = rsp_dat_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_last      = rsp_last_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_sel_o = sel_q;
endmodule
